// File: rtl/gp_seq_pkg.sv
// Shared definitions for the general-purpose register sequencer:
// opcodes, FSM state encoding and settle counter width.
package gp_seq_pkg;

  localparam int CNT_W = 4;

  localparam logic [1:0] OP_MOV     = 2'b00;
  localparam logic [1:0] OP_LOAD    = 2'b01;
  localparam logic [1:0] OP_STORE   = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_LATCH = 2'd2,
    S_TURN  = 2'd3
  } state_e;

endpackage

// File: rtl/gp_register_sequencer_dec.sv
// Enable plus index to active-low one-hot select. Indices at or beyond
// NUM_REGS select nothing, so all outputs stay high.
module gp_sel_decoder #(
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3
) (
  input  logic                en_i,
  input  logic [SEL_W-1:0]    idx_i,
  output logic [NUM_REGS-1:0] n_sel_o
);

  always_comb begin
    n_sel_o = '1;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en_i && (idx_i == SEL_W'(i))) n_sel_o[i] = 1'b0;
    end
  end

endmodule

// File: rtl/gp_register_sequencer.sv
// Generates per-register output-enable and load strobes for transfers on a
// shared bus: drive, latch, then a turnaround cycle before the next driver.
module gp_register_sequencer
  import gp_seq_pkg::*;
#(
  parameter int NUM_REGS      = 8,
  parameter int SEL_W         = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clock,
  input  logic                notReset,
  input  logic                cmdValid,
  output logic                cmdReady,
  input  logic [1:0]          cmdOp,
  input  logic [SEL_W-1:0]    cmdSrc,
  input  logic [SEL_W-1:0]    cmdDst,
  output logic [NUM_REGS-1:0] notOE,
  output logic [NUM_REGS-1:0] notLoad,
  output logic                extDriveEn,
  output logic                extSample,
  output logic                done,
  output logic                cmdError
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [SEL_W-1:0]   src_q, src_d;
  logic [SEL_W-1:0]   dst_q, dst_d;
  logic               err_q, err_d;

  logic               ready_q;
  logic [NUM_REGS-1:0] n_oe_q, n_oe_d;
  logic [NUM_REGS-1:0] n_load_q, n_load_d;
  logic               ext_drv_q, ext_drv_d;
  logic               ext_smp_q, ext_smp_d;
  logic               done_q, err_out_q;
  logic               oe_en, load_en;

  // Only the fields an opcode actually uses are range-checked.
  function automatic logic cmd_illegal(input logic [1:0] op,
                                       input logic [SEL_W-1:0] src,
                                       input logic [SEL_W-1:0] dst);
    logic src_bad, dst_bad;
    src_bad = (int'(src) >= NUM_REGS);
    dst_bad = (int'(dst) >= NUM_REGS);
    case (op)
      OP_MOV:   cmd_illegal = src_bad || dst_bad;
      OP_LOAD:  cmd_illegal = dst_bad;
      OP_STORE: cmd_illegal = src_bad;
      default:  cmd_illegal = 1'b1;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmdValid && ready_q) begin
          op_d    = cmdOp;
          src_d   = cmdSrc;
          dst_d   = cmdDst;
          err_d   = cmd_illegal(cmdOp, cmdSrc, cmdDst);
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          state_d = err_d ? S_TURN : S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (cnt_q == '0) state_d = S_LATCH;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_LATCH: state_d = S_TURN;
      S_TURN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they line up with it.
  always_comb begin
    oe_en     = ((state_d == S_DRIVE) || (state_d == S_LATCH)) &&
                ((op_d == OP_MOV) || (op_d == OP_STORE));
    load_en   = (state_d == S_LATCH) && ((op_d == OP_MOV) || (op_d == OP_LOAD));
    ext_drv_d = ((state_d == S_DRIVE) || (state_d == S_LATCH)) && (op_d == OP_LOAD);
    ext_smp_d = (state_d == S_LATCH) && (op_d == OP_STORE);
  end

  gp_sel_decoder #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_oe_dec (
    .en_i    (oe_en),
    .idx_i   (src_d),
    .n_sel_o (n_oe_d)
  );

  gp_sel_decoder #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_load_dec (
    .en_i    (load_en),
    .idx_i   (dst_d),
    .n_sel_o (n_load_d)
  );

  always_ff @(posedge clock) begin
    if (!notReset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      n_oe_q    <= '1;
      n_load_q  <= '1;
      ext_drv_q <= 1'b0;
      ext_smp_q <= 1'b0;
      done_q    <= 1'b0;
      err_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      ready_q   <= (state_d == S_IDLE);
      n_oe_q    <= n_oe_d;
      n_load_q  <= n_load_d;
      ext_drv_q <= ext_drv_d;
      ext_smp_q <= ext_smp_d;
      done_q    <= (state_d == S_TURN);
      err_out_q <= (state_d == S_TURN) && err_d;
    end
  end

  // Command fields are pure data and need no reset.
  always_ff @(posedge clock) begin
    op_q  <= op_d;
    src_q <= src_d;
    dst_q <= dst_d;
  end

  assign cmdReady   = ready_q;
  assign notOE      = n_oe_q;
  assign notLoad    = n_load_q;
  assign extDriveEn = ext_drv_q;
  assign extSample  = ext_smp_q;
  assign done       = done_q;
  assign cmdError   = err_out_q;

endmodule
